// File: rtl/mem_io_responder_pkg.sv
// Shared I/O address map and decode helpers for the memory/I/O responder.
// The I/O window is selected by address bits [17:16] == 2'b11.
package mem_io_responder_pkg;

  localparam int          BYTE_W  = 8;
  localparam logic [1:0]  IO_SEL  = 2'b11;
  localparam logic [17:0] IO_UART = 18'h30000;
  localparam logic [17:0] IO_CNT  = 18'h30004;

  typedef enum logic [2:0] {
    IO_OTHER,
    IO_UART_DATA,
    IO_CNT_B0,
    IO_CNT_B1,
    IO_CNT_B2,
    IO_CNT_B3
  } io_reg_e;

  function automatic logic is_io(input logic [31:0] a);
    return a[17:16] == IO_SEL;
  endfunction

  function automatic io_reg_e decode_io(input logic [31:0] a);
    io_reg_e r;
    case (a[17:0])
      IO_UART:          r = IO_UART_DATA;
      IO_CNT:           r = IO_CNT_B0;
      IO_CNT + 18'd1:   r = IO_CNT_B1;
      IO_CNT + 18'd2:   r = IO_CNT_B2;
      IO_CNT + 18'd3:   r = IO_CNT_B3;
      default:          r = IO_OTHER;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// First-word-fall-through byte FIFO with occupancy count and sticky drop flag.
// A push into a full FIFO succeeds only when a real pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [7:0]                 i_data,
  input  logic                       i_pop,
  output logic [7:0]                 o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // Popping an empty FIFO is ignored so a push/pop on empty is a plain push.
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_push && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_data     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/mem_io_responder.sv
// CPU bus responder: byte RAM with one-cycle read latency plus a small I/O window
// (UART TX/RX byte FIFOs, snapshotting cycle counter, program-stop strobe).
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        program_stop,
  output logic        rx_overflow,
  output logic        tx_overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] NEAR_FULL = CNT_W'(FIFO_DEPTH - 1);

  logic [BYTE_W-1:0] r_ram [2**RAM_ADDR_W];
  logic [BYTE_W-1:0] r_ram_q;
  logic [BYTE_W-1:0] r_io_q;
  logic              r_sel_ram;
  logic [31:0]       r_cycle;
  logic [31:0]       r_snap;
  logic              r_stop;

  logic              w_is_io;
  io_reg_e           w_io_reg;
  logic              w_ram_rd;
  logic              w_ram_wr;
  logic              w_tx_push;
  logic [7:0]        w_tx_wdata;
  logic              w_rx_pop;
  logic [7:0]        w_io_rdata;
  logic              w_snap_load;
  logic              w_stop;
  logic [7:0]        w_rx_head;
  logic [CNT_W-1:0]  w_tx_count;
  logic [CNT_W-1:0]  w_rx_count;
  logic              w_rx_empty;

  assign w_is_io  = is_io(mem_a);
  assign w_io_reg = decode_io(mem_a);
  assign w_ram_rd = !mem_wr && !w_is_io;
  // RAM contents must survive a reset, so writes are blocked while it is held.
  assign w_ram_wr = mem_wr && !w_is_io && rst_in;

  always_ff @(posedge clk_in) begin
    if (w_ram_wr) begin
      r_ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
    end
    if (w_ram_rd) begin
      r_ram_q <= r_ram[mem_a[RAM_ADDR_W-1:0]];
    end
  end

  assign w_rx_empty = (w_rx_count == '0);

  always_comb begin
    w_tx_push   = 1'b0;
    w_tx_wdata  = 8'h00;
    w_rx_pop    = 1'b0;
    w_io_rdata  = 8'h00;
    w_snap_load = 1'b0;
    w_stop      = 1'b0;
    if (w_is_io) begin
      if (mem_wr) begin
        case (w_io_reg)
          IO_UART_DATA: w_tx_push = (mem_dout != 8'h00);
          IO_CNT_B0: begin
            w_tx_push = 1'b1;
            w_stop    = 1'b1;
          end
          default: ;
        endcase
        w_tx_wdata = (w_io_reg == IO_UART_DATA) ? mem_dout : 8'h00;
      end else begin
        case (w_io_reg)
          IO_UART_DATA: begin
            w_rx_pop   = !w_rx_empty;
            w_io_rdata = w_rx_empty ? 8'h00 : w_rx_head;
          end
          IO_CNT_B0: begin
            w_snap_load = 1'b1;
            w_io_rdata  = r_cycle[7:0];
          end
          IO_CNT_B1: w_io_rdata = r_snap[15:8];
          IO_CNT_B2: w_io_rdata = r_snap[23:16];
          IO_CNT_B3: w_io_rdata = r_snap[31:24];
          default:   w_io_rdata = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_io_q    <= 8'h00;
      r_sel_ram <= 1'b0;
      r_cycle   <= 32'd0;
      r_snap    <= 32'd0;
      r_stop    <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      r_stop  <= w_stop;
      if (w_snap_load) begin
        r_snap <= r_cycle;
      end
      // Write cycles leave the returned byte untouched.
      if (!mem_wr) begin
        r_sel_ram <= !w_is_io;
        if (w_is_io) begin
          r_io_q <= w_io_rdata;
        end
      end
    end
  end

  assign mem_din      = r_sel_ram ? r_ram_q : r_io_q;
  assign program_stop = r_stop;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk      (clk_in),
    .i_rst_n    (rst_in),
    .i_push     (w_tx_push),
    .i_data     (w_tx_wdata),
    .i_pop      (tx_ready),
    .o_data     (tx_data),
    .o_count    (w_tx_count),
    .o_overflow (tx_overflow)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk      (clk_in),
    .i_rst_n    (rst_in),
    .i_push     (rx_valid),
    .i_data     (rx_data),
    .i_pop      (w_rx_pop),
    .o_data     (w_rx_head),
    .o_count    (w_rx_count),
    .o_overflow (rx_overflow)
  );

  assign tx_valid       = (w_tx_count != '0);
  assign io_buffer_full = (w_tx_count >= NEAR_FULL);

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: fixed vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_mem_io_responder;

  localparam int D  = 8;
  localparam int AW = 17;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] mem_a = 32'h0003_0008;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = 8'h00;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        program_stop;
  logic        rx_overflow;
  logic        tx_overflow;

  mem_io_responder #(.RAM_ADDR_W(AW), .FIFO_DEPTH(D)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_dout       (mem_dout),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .program_stop   (program_stop),
    .rx_overflow    (rx_overflow),
    .tx_overflow    (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // Reference model state
  logic [7:0]  m_ram [int];
  logic [7:0]  q_tx [$];
  logic [7:0]  q_rx [$];
  logic [31:0] m_cnt;
  logic [31:0] m_snap;
  logic [7:0]  m_din;
  logic        m_stop;
  logic        m_txo;
  logic        m_rxo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
    logic        txr;
    logic [7:0]  rxd;
    logic        rxv;
    logic [7:0]  e_din;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic        e_full;
    logic        e_stop;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q_tx.delete();
    q_rx.delete();
    m_cnt  = 32'd0;
    m_snap = 32'd0;
    m_din  = 8'h00;
    m_stop = 1'b0;
    m_txo  = 1'b0;
    m_rxo  = 1'b0;
  endtask

  // Called at posedge+1; asserts reset between edges and checks it takes effect at once.
  task automatic do_reset();
    mem_a = 32'h0003_0008; mem_wr = 1'b0; mem_dout = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    rst_in = 1'b0;
    #1;
    chk("rst mem_din", mem_din, 0);
    chk("rst tx_valid", tx_valid, 0);
    chk("rst program_stop", program_stop, 0);
    chk("rst tx_overflow", tx_overflow, 0);
    chk("rst rx_overflow", rx_overflow, 0);
    chk("rst io_buffer_full", io_buffer_full, 0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    model_reset();
  endtask

  // One bus cycle: drive, advance the model, clock, compare every output.
  task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d,
                     input logic txr, input logic [7:0] rxd, input logic rxv);
    logic        io;
    logic [17:0] off;
    int          txn, rxn;
    logic        txpop, rxpop, txpush;
    logic [7:0]  txval;
    mem_a = a; mem_wr = wr; mem_dout = d;
    tx_ready = txr; rx_data = rxd; rx_valid = rxv;

    io = (a[17:16] == 2'b11);
    off = a[17:0];
    txn = q_tx.size();
    rxn = q_rx.size();
    txpop = txr && (txn > 0);
    rxpop = 1'b0;
    txpush = 1'b0;
    txval = 8'h00;
    m_stop = 1'b0;
    if (!wr) begin
      if (!io) m_din = m_ram[int'(a[AW-1:0])];
      else if (off == 18'h30000) begin
        if (rxn > 0) begin m_din = q_rx[0]; rxpop = 1'b1; end
        else m_din = 8'h00;
      end
      else if (off == 18'h30004) begin m_snap = m_cnt; m_din = m_cnt[7:0]; end
      else if (off == 18'h30005) m_din = m_snap[15:8];
      else if (off == 18'h30006) m_din = m_snap[23:16];
      else if (off == 18'h30007) m_din = m_snap[31:24];
      else m_din = 8'h00;
    end else begin
      if (!io) m_ram[int'(a[AW-1:0])] = d;
      else if (off == 18'h30000 && d != 8'h00) begin txpush = 1'b1; txval = d; end
      else if (off == 18'h30004) begin txpush = 1'b1; txval = 8'h00; m_stop = 1'b1; end
    end
    if (txpop) void'(q_tx.pop_front());
    if (rxpop) void'(q_rx.pop_front());
    if (txpush) begin
      if (txn < D || txpop) q_tx.push_back(txval);
      else m_txo = 1'b1;
    end
    if (rxv) begin
      if (rxn < D || rxpop) q_rx.push_back(rxd);
      else m_rxo = 1'b1;
    end
    m_cnt = m_cnt + 32'd1;

    @(posedge clk_in);
    #1;
    chk("mem_din", mem_din, m_din);
    chk("tx_valid", tx_valid, q_tx.size() != 0);
    if (q_tx.size() != 0) chk("tx_data", tx_data, q_tx[0]);
    chk("io_buffer_full", io_buffer_full, q_tx.size() >= D - 1);
    chk("program_stop", program_stop, m_stop);
    chk("tx_overflow", tx_overflow, m_txo);
    chk("rx_overflow", rx_overflow, m_rxo);
  endtask

  task automatic idle(input logic txr);
    cyc(32'h0003_0008, 1'b0, 8'h00, txr, 8'h00, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pool [8];
    logic [31:0] snapv;
    logic [31:0] a;
    logic        wr;
    int          r;

    vecs[0] = '{32'h0000_0100, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{32'h0003_0008, 1'b0, 8'h00, 1'b0, 8'h41, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h41, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{32'h0003_0004, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[8] = '{32'h0003_0009, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{32'h0000_0100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0};

    @(posedge clk_in);
    #1;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].a, vecs[i].wr, vecs[i].d, vecs[i].txr, vecs[i].rxd, vecs[i].rxv);
      chk("vec mem_din", mem_din, vecs[i].e_din);
      chk("vec tx_valid", tx_valid, vecs[i].e_txv);
      if (vecs[i].e_txv) chk("vec tx_data", tx_data, vecs[i].e_txd);
      chk("vec io_buffer_full", io_buffer_full, vecs[i].e_full);
      chk("vec program_stop", program_stop, vecs[i].e_stop);
      $display("vec %0d a=%h wr=%0b d=%h -> din=%h txv=%0b stop=%0b",
               i, vecs[i].a, vecs[i].wr, vecs[i].d, mem_din, tx_valid, program_stop);
    end

    // 'H','i' then an ignored zero byte, drained in order
    do_reset();
    cyc(32'h0003_0000, 1'b1, 8'h48, 1'b0, 8'h00, 1'b0);
    cyc(32'h0003_0000, 1'b1, 8'h69, 1'b0, 8'h00, 1'b0);
    cyc(32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("hi head", tx_data, 8'h48);
    idle(1'b1);
    chk("hi second", tx_data, 8'h69);
    chk("hi second valid", tx_valid, 1);
    idle(1'b1);
    chk("hi drained", tx_valid, 0);
    $display("seq hi done");

    // Near-full back-pressure and overflow on a blocked TX FIFO
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      cyc(32'h0003_0000, 1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
      if (i == 6) chk("full after 6", io_buffer_full, 0);
      if (i == 7) chk("full after 7", io_buffer_full, 1);
      if (i == 8) chk("no ovf after 8", tx_overflow, 0);
      if (i == 9) chk("ovf after 9", tx_overflow, 1);
    end
    for (int i = 0; i < 9; i++) idle(1'b1);
    chk("drained after ovf", tx_valid, 0);
    $display("seq txfull done");

    // Counter snapshot after 300 idle cycles
    do_reset();
    for (int i = 0; i < 300; i++) idle(1'b0);
    snapv = 32'd0;
    for (int i = 0; i < 4; i++) begin
      cyc(32'h0003_0004 + 32'(i), 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      snapv[i*8 +: 8] = mem_din;
    end
    chk("snapshot value", snapv, 32'd300);
    $display("seq snapshot done value=%0d", snapv);

    // Random traffic against the model
    pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0005; pool[2] = 32'h0002_0005;
    pool[3] = 32'h0001_FFFF; pool[4] = 32'h0000_FFFF; pool[5] = 32'h0000_2345;
    pool[6] = 32'h0001_0000; pool[7] = 32'h0000_0101;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      wr = $urandom_range(0, 1) == 1;
      if (r <= 3) begin
        a = pool[$urandom_range(0, 7)];
        if (!wr && !m_ram.exists(int'(a[AW-1:0]))) wr = 1'b1;
      end
      else if (r <= 5) a = 32'h0003_0000;
      else if (r == 6) a = 32'h0003_0004;
      else if (r == 7) a = 32'h0003_0004 + 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'h0003_0001;
      else a = 32'h0003_FFFF;
      cyc(a, wr, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
          (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
          8'($urandom), $urandom_range(0, 1) == 1);
    end
    $display("random phase done");

    // Mid-operation reset: pending FIFO data discarded, counter restarts at 0
    cyc(32'h0003_0000, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
    do_reset();
    cyc(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("post-reset counter", mem_din, 8'h00);
    chk("post-reset tx empty", tx_valid, 0);
    cyc(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("post-reset rx empty", mem_din, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
